// File: rtl/evu_pkg.sv
// Shared types and constants for the event-unit counter bank.
// Selector encodings mirror the evu_mux input ordering.
package evu_pkg;

   localparam int EVU_SEL_W = 4;

   typedef enum logic [1:0] {
      EVU_REG_CNT = 2'b00,
      EVU_REG_SEL = 2'b01,
      EVU_REG_INH = 2'b10,
      EVU_REG_OVF = 2'b11
   } evu_csr_region_t;

   // Codes 0 and 1 select no event in the mux.
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_OFF            = 4'h0;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_NONE           = 4'h1;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_ICACHE_MISS    = 4'h2;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_DCACHE_MISS    = 4'h3;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_BRANCH         = 4'h4;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_BRANCH_TAKEN   = 4'h5;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_LOAD           = 4'h6;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_STORE          = 4'h7;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_LOAD_USE_STALL = 4'h8;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_JUMP           = 4'h9;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_IMISS_STALL    = 4'hA;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_LSU_STALL      = 4'hB;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_CTRL_HAZARD    = 4'hC;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_CSR_STALL      = 4'hD;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_COMP_INSTR     = 4'hE;
   localparam logic [EVU_SEL_W-1:0] EVU_SEL_IF_EMPTY       = 4'hF;

endpackage

// File: rtl/evu_counter_slice.sv
// One counter/selector pair: counter, selector, post-write blank flag and overflow bit.
// Overflow storage exists only when EVU_OVF_IRQ_EN is defined.
module evu_counter_slice
   import evu_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 event_i,
   input  logic                 inhibit_i,
   input  logic                 debug_mode_i,
   input  logic                 cnt_we_i,
   input  logic                 sel_we_i,
   input  logic                 ovf_clr_i,
   input  logic [CNT_W-1:0]     wdata_i,
   output logic [CNT_W-1:0]     cnt_o,
   output logic [EVU_SEL_W-1:0] sel_o,
   output logic                 ovf_o
);

   logic [CNT_W-1:0]     cnt_q;
   logic [EVU_SEL_W-1:0] sel_q;
   logic                 blank_q;
   logic                 count_en;

   // The mux output is registered, so the cycle after a selector change still carries the old event.
   assign count_en = event_i & ~inhibit_i & ~debug_mode_i & ~blank_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         sel_q   <= EVU_SEL_OFF;
         blank_q <= 1'b0;
      end else begin
         blank_q <= sel_we_i;
         if (sel_we_i)
            sel_q <= wdata_i[EVU_SEL_W-1:0];
         if (cnt_we_i)
            cnt_q <= wdata_i;
         else if (count_en)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

`ifdef EVU_OVF_IRQ_EN
   logic ovf_q;
   logic wrap;

   // A wrap in the same cycle as a clear of this bit keeps the bit set.
   assign wrap = count_en & ~cnt_we_i & (&cnt_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ovf_q <= 1'b0;
      else if (wrap)
         ovf_q <= 1'b1;
      else if (ovf_clr_i)
         ovf_q <= 1'b0;
   end

   assign ovf_o = ovf_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr_i;
   assign ovf_o          = 1'b0;
`endif

   assign cnt_o = cnt_q;
   assign sel_o = sel_q;

endmodule

// File: rtl/evu_counter_bank.sv
// Event counter bank: CSR decode, one-cycle response register and overflow irq.
// EVU_OVF_IRQ_EN enables overflow status (W1C) and irq_o; otherwise region 11 reads 0 and irq_o is 0.
module evu_counter_bank
   import evu_pkg::*;
#(
   parameter int NR_COUNTERS = 4,
   parameter int CNT_W       = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             debug_mode_i,
   input  logic [NR_COUNTERS-1:0]           event_i,
   output logic [EVU_SEL_W*NR_COUNTERS-1:0] sel_line_o,
   input  logic                             csr_req_i,
   input  logic                             csr_we_i,
   input  logic [4:0]                       csr_addr_i,
   input  logic [CNT_W-1:0]                 csr_wdata_i,
   output logic                             csr_rvalid_o,
   output logic [CNT_W-1:0]                 csr_rdata_o,
   output logic                             csr_err_o,
   output logic                             irq_o
);

   evu_csr_region_t        region;
   logic [2:0]             idx;
   logic                   idx_ok;
   logic                   acc_err;
   logic                   wr;
   logic [CNT_W-1:0]       rd_data;

   logic [NR_COUNTERS-1:0] inh_q;
   logic [NR_COUNTERS-1:0] cnt_we;
   logic [NR_COUNTERS-1:0] sel_we;
   logic [NR_COUNTERS-1:0] ovf_clr;
   logic [NR_COUNTERS-1:0] ovf;
   logic [CNT_W-1:0]       cnt     [NR_COUNTERS];
   logic [EVU_SEL_W-1:0]   sel     [NR_COUNTERS];

   assign region  = evu_csr_region_t'(csr_addr_i[4:3]);
   assign idx     = csr_addr_i[2:0];
   assign idx_ok  = (32'(idx) < NR_COUNTERS);
   assign acc_err = ((region == EVU_REG_CNT) || (region == EVU_REG_SEL)) && !idx_ok;
   assign wr      = csr_req_i & csr_we_i;

   for (genvar k = 0; k < NR_COUNTERS; k++) begin : g_slice
      assign cnt_we[k]  = wr && (region == EVU_REG_CNT) && (idx == 3'(k));
      assign sel_we[k]  = wr && (region == EVU_REG_SEL) && (idx == 3'(k));
      assign ovf_clr[k] = wr && (region == EVU_REG_OVF) && csr_wdata_i[k];

      evu_counter_slice #(
         .CNT_W (CNT_W)
      ) u_slice (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .event_i      (event_i[k]),
         .inhibit_i    (inh_q[k]),
         .debug_mode_i (debug_mode_i),
         .cnt_we_i     (cnt_we[k]),
         .sel_we_i     (sel_we[k]),
         .ovf_clr_i    (ovf_clr[k]),
         .wdata_i      (csr_wdata_i),
         .cnt_o        (cnt[k]),
         .sel_o        (sel[k]),
         .ovf_o        (ovf[k])
      );

      assign sel_line_o[EVU_SEL_W*k +: EVU_SEL_W] = sel[k];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         inh_q <= '0;
      else if (wr && (region == EVU_REG_INH))
         inh_q <= csr_wdata_i[NR_COUNTERS-1:0];
   end

   // Reads sample state before this edge's updates, so a concurrent increment is not visible.
   always_comb begin
      rd_data = '0;
      case (region)
         EVU_REG_CNT: begin
            for (int k = 0; k < NR_COUNTERS; k++)
               if (idx == 3'(k)) rd_data = cnt[k];
         end
         EVU_REG_SEL: begin
            for (int k = 0; k < NR_COUNTERS; k++)
               if (idx == 3'(k)) rd_data = CNT_W'(sel[k]);
         end
         EVU_REG_INH: rd_data = CNT_W'(inh_q);
         EVU_REG_OVF: rd_data = CNT_W'(ovf);
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         csr_rvalid_o <= 1'b0;
         csr_rdata_o  <= '0;
         csr_err_o    <= 1'b0;
      end else begin
         csr_rvalid_o <= csr_req_i;
         csr_err_o    <= csr_req_i & acc_err;
         csr_rdata_o  <= (csr_req_i && !csr_we_i && !acc_err) ? rd_data : '0;
      end
   end

`ifdef EVU_OVF_IRQ_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         irq_o <= 1'b0;
      else
         irq_o <= |ovf;
   end
`else
   assign irq_o = 1'b0;
`endif

endmodule
